// File: rtl/host_wr_ctrl_pkg.sv
// Shared encodings for the host write controller: register selects, write
// targets, default memory address widths and the wrapping pointer increment.
package host_wr_pkg;

    localparam logic [1:0] RS_ADDR_LO = 2'd0;
    localparam logic [1:0] RS_ADDR_HI = 2'd1;
    localparam logic [1:0] RS_DATA    = 2'd2;
    localparam logic [1:0] RS_CTRL    = 2'd3;

    typedef enum logic [1:0] {
        TGT_CHROW = 2'b00,
        TGT_PAL   = 2'b01,
        TGT_FONT  = 2'b10,
        TGT_NONE  = 2'b11
    } tgt_e;

    localparam int CHROW_AW_DEF = 8;
    localparam int PAL_AW_DEF   = 8;
    localparam int FONT_AW_DEF  = 12;
    localparam int PTR_W        = 12;

    // Increment only the low aw bits; the bits above the target's width are kept.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p, input int aw);
        logic [PTR_W-1:0] mask;
        mask = PTR_W'((13'd1 << aw) - 13'd1);
        return (p & ~mask) | ((p + PTR_W'(1)) & mask);
    endfunction

endpackage

// File: rtl/host_wr_ctrl_sync_fall.sv
// Two-flop synchroniser for an async active-low strobe plus a history flop;
// emits a one-cycle pulse when the synchronised strobe falls.
module sync_fall (
    input  logic clk,
    input  logic nrst,
    input  logic async_i,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic hist_q;

    // Resetting low means a pulse interrupted by reset never re-fires on release.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            hist_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            hist_q <= sync_q;
        end
    end

    assign fall_o = hist_q & ~sync_q;

endmodule

// File: rtl/host_wr_ctrl.sv
// Host byte-bus writer for chrowbuf, palette and fontmem: decodes each host
// strobe into an address/target update or a single-cycle memory write.
module host_wr_ctrl
    import host_wr_pkg::*;
#(
    parameter int CHROW_AW = CHROW_AW_DEF,
    parameter int PAL_AW   = PAL_AW_DEF,
    parameter int FONT_AW  = FONT_AW_DEF
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                host_nwr,
    input  logic [1:0]          host_rs,
    input  logic [7:0]          host_data,
    output logic                chrowbuf_wr,
    output logic [CHROW_AW-1:0] chrowbuf_wr_addr,
    output logic [15:0]         chrowbuf_wr_data,
    output logic                palette_wr,
    output logic [PAL_AW-1:0]   palette_wr_addr,
    output logic [15:0]         palette_wr_data,
    output logic                fontmem_wr,
    output logic [FONT_AW-1:0]  fontmem_wr_addr,
    output logic [7:0]          fontmem_wr_data,
    output logic                pending
);

    logic                fall;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    tgt_e                tgt_q, tgt_d;
    logic                pend_q, pend_d;
    logic [7:0]          lo_q, lo_d;
    logic                chrow_wr_q, chrow_wr_d;
    logic [CHROW_AW-1:0] chrow_addr_q, chrow_addr_d;
    logic [15:0]         chrow_data_q, chrow_data_d;
    logic                pal_wr_q, pal_wr_d;
    logic [PAL_AW-1:0]   pal_addr_q, pal_addr_d;
    logic [15:0]         pal_data_q, pal_data_d;
    logic                font_wr_q, font_wr_d;
    logic [FONT_AW-1:0]  font_addr_q, font_addr_d;
    logic [7:0]          font_data_q, font_data_d;

    sync_fall u_sync (
        .clk     (clk),
        .nrst    (nrst),
        .async_i (host_nwr),
        .fall_o  (fall)
    );

    // rs/data are taken straight from the pins: the host holds them until nwr rises.
    always_comb begin
        ptr_d        = ptr_q;
        tgt_d        = tgt_q;
        pend_d       = pend_q;
        lo_d         = lo_q;
        chrow_wr_d   = 1'b1;
        chrow_addr_d = chrow_addr_q;
        chrow_data_d = chrow_data_q;
        pal_wr_d     = 1'b1;
        pal_addr_d   = pal_addr_q;
        pal_data_d   = pal_data_q;
        font_wr_d    = 1'b1;
        font_addr_d  = font_addr_q;
        font_data_d  = font_data_q;
        if (fall) begin
            case (host_rs)
                RS_ADDR_LO: begin
                    ptr_d[7:0] = host_data;
                    pend_d     = 1'b0;
                end
                RS_ADDR_HI: begin
                    ptr_d[11:8] = host_data[3:0];
                    tgt_d       = tgt_e'(host_data[5:4]);
                    pend_d      = 1'b0;
                end
                RS_DATA: begin
                    case (tgt_q)
                        TGT_CHROW, TGT_PAL: begin
                            if (!pend_q) begin
                                lo_d   = host_data;
                                pend_d = 1'b1;
                            end else if (tgt_q == TGT_CHROW) begin
                                chrow_wr_d   = 1'b0;
                                chrow_addr_d = ptr_q[CHROW_AW-1:0];
                                chrow_data_d = {host_data, lo_q};
                                ptr_d        = ptr_inc(ptr_q, CHROW_AW);
                                pend_d       = 1'b0;
                            end else begin
                                pal_wr_d   = 1'b0;
                                pal_addr_d = ptr_q[PAL_AW-1:0];
                                pal_data_d = {host_data, lo_q};
                                ptr_d      = ptr_inc(ptr_q, PAL_AW);
                                pend_d     = 1'b0;
                            end
                        end
                        TGT_FONT: begin
                            font_wr_d   = 1'b0;
                            font_addr_d = ptr_q[FONT_AW-1:0];
                            font_data_d = host_data;
                            ptr_d       = ptr_inc(ptr_q, FONT_AW);
                        end
                        default: ;
                    endcase
                end
                default: begin
                    if (host_data[0]) pend_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ptr_q        <= '0;
            tgt_q        <= TGT_CHROW;
            pend_q       <= 1'b0;
            lo_q         <= '0;
            chrow_wr_q   <= 1'b1;
            chrow_addr_q <= '0;
            chrow_data_q <= '0;
            pal_wr_q     <= 1'b1;
            pal_addr_q   <= '0;
            pal_data_q   <= '0;
            font_wr_q    <= 1'b1;
            font_addr_q  <= '0;
            font_data_q  <= '0;
        end else begin
            ptr_q        <= ptr_d;
            tgt_q        <= tgt_d;
            pend_q       <= pend_d;
            lo_q         <= lo_d;
            chrow_wr_q   <= chrow_wr_d;
            chrow_addr_q <= chrow_addr_d;
            chrow_data_q <= chrow_data_d;
            pal_wr_q     <= pal_wr_d;
            pal_addr_q   <= pal_addr_d;
            pal_data_q   <= pal_data_d;
            font_wr_q    <= font_wr_d;
            font_addr_q  <= font_addr_d;
            font_data_q  <= font_data_d;
        end
    end

    assign chrowbuf_wr      = chrow_wr_q;
    assign chrowbuf_wr_addr = chrow_addr_q;
    assign chrowbuf_wr_data = chrow_data_q;
    assign palette_wr       = pal_wr_q;
    assign palette_wr_addr  = pal_addr_q;
    assign palette_wr_data  = pal_data_q;
    assign fontmem_wr       = font_wr_q;
    assign fontmem_wr_addr  = font_addr_q;
    assign fontmem_wr_data  = font_data_q;
    assign pending          = pend_q;

endmodule
